// File: rtl/rs232_pkg.sv
// rs232_pkg: shared state codes and bit-timing helpers
// for the rs232 serializer/deserializer pair.
package rs232_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  // clocks per bit, truncated
  function automatic int rs232_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  // baud counter width, never below one bit
  function automatic int rs232_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/rs232_ser_if.sv
// rs232_ser_if: TX FIFO read port (normal-mode q,
// data valid the cycle after rd_en).
interface rs232_ser_if;
  logic [7:0] data;
  logic       empty;
  logic       rd_en;

  modport master (
    output rd_en,
    input  data,
    input  empty
  );

  modport slave (
    input  rd_en,
    output data,
    output empty
  );
endinterface

// File: rtl/rs232_baud_gen.sv
// rs232_baud_gen: bit-period counter; tick on the last
// cycle of each period, clear restarts from zero.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int P_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = rs232_cnt_w(P_DIV);
  localparam logic [W-1:0] LAST = W'(P_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // count up, wrap at the period boundary
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + W'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rs232_ser.sv
// rs232_ser: 8N1 UART transmitter fed from an external FIFO.
// Define RS232_SER_CTS_EN to gate sends on synchronized cts_n.
module rs232_ser
  import rs232_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 50000000,
  parameter int P_BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_fifo_data,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_rd_en,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy
);

  localparam int DIV =
    rs232_div(P_CLK_FREQ_HZ, P_BAUD_RATE);

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       rd_en;
  logic       clear;
  logic       tick;
  logic       send_ok;

`ifdef RS232_SER_CTS_EN
  logic cts_meta_q, cts_meta_d;
  logic cts_sync_q, cts_sync_d;

  // two-stage synchronizer feed
  always_comb begin
    cts_meta_d = cts_n;
    cts_sync_d = cts_meta_q;
  end

  // synchronizer flops, reset to not-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign send_ok = !tx_fifo_empty && !cts_sync_q;
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign send_ok    = !tx_fifo_empty;
`endif

  rs232_baud_gen #(
    .P_DIV (DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // next state, shift/bit index and next tx level
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rd_en   = 1'b0;
    clear   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        tx_d = 1'b1;
        if (!tx_fifo_empty) begin
          rd_en   = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = tx_fifo_data;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        clear = 1'b0;
        if (tick) begin
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        clear = 1'b0;
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d = shift_q[bit_d];
          end
        end
      end
      S_STOP: begin
        clear = 1'b0;
        tx_d  = 1'b1;
        if (tick) begin
          state_d = send_ok ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // frame state registers; tx comes straight off tx_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign tx            = tx_q;
  assign tx_fifo_rd_en = rd_en;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_ser.sv
// tb_rs232_ser: directed checks of rs232_ser at default
// timing and at DIV=3.
module tb_rs232_ser;

  localparam int DIV  = 434;
  localparam int DIV3 = 3;
`ifdef RS232_SER_CTS_EN
  localparam int LAT  = 3;
`else
  localparam int LAT  = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cts_n;
  logic tx;
  logic busy;

  rs232_ser_if ff();

  logic [7:0] data3;
  logic       empty3;
  logic       rd3;
  logic       tx3;
  logic       busy3;

  logic [7:0] q[$];
  int rd_cnt  = 0;
  int rd3_cnt = 0;
  int viol    = 0;
  int n_vec   = 0;
  int n_bad   = 0;

  rs232_ser u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_fifo_data  (ff.data),
    .tx_fifo_empty (ff.empty),
    .tx_fifo_rd_en (ff.rd_en),
    .cts_n         (cts_n),
    .tx            (tx),
    .busy          (busy)
  );

  rs232_ser #(
    .P_CLK_FREQ_HZ (1000),
    .P_BAUD_RATE   (300)
  ) u_dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_fifo_data  (data3),
    .tx_fifo_empty (empty3),
    .tx_fifo_rd_en (rd3),
    .cts_n         (cts_n),
    .tx            (tx3),
    .busy          (busy3)
  );

  // normal-mode FIFO model: q valid the cycle after rd_en
  always @(posedge clk) begin
    if (ff.rd_en) begin
      if (ff.empty) viol++;
      else begin
        ff.data <= q.pop_front();
        rd_cnt++;
      end
    end
    ff.empty <= (q.size() == 0);
    if (rd3) begin
      rd3_cnt++;
      if (empty3) viol++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? tx3 : tx;
  endfunction

  // n consecutive negedge samples must equal lvl
  task automatic chk_bit(input logic lvl, input int n,
                         input int sel, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (line(sel) !== lvl) bad++;
      @(negedge clk);
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_frame(input logic [7:0] b,
                           input int div, input int sel,
                           input string tag);
    chk_bit(1'b0, div, sel, {tag, "_start"});
    for (int k = 0; k < 8; k++)
      chk_bit(b[k], div, sel, $sformatf("%s_d%0d", tag, k));
    chk_bit(1'b1, div, sel, {tag, "_stop"});
  endtask

  task automatic wait_start(input int budget, input int sel,
                            input string tag);
    int n = 0;
    while (line(sel) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, line(sel), 0);
  endtask

  int rd0;
  int n;
  logic [7:0] b4;

  initial begin
    rst_n  = 1'b0;
`ifdef RS232_SER_CTS_EN
    cts_n  = 1'b0;
`else
    cts_n  = 1'b1;
`endif
    data3  = 8'hC3;
    empty3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd", ff.rd_en, 0);
    chk("rst_tx3", tx3, 1);

    // single byte 0x55, first read after reset release
    q.push_back(8'h55);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("t1_rd_hold", ff.rd_en, 0);
    repeat (LAT) @(negedge clk);
    chk("t1_rd_first", ff.rd_en, 1);
    chk_bit(1'b1, 2, 0, "t1_pre");
    chk_bit(1'b0, DIV, 0, "t1_start");
    chk("t1_busy_mid", busy, 1);
    b4 = 8'h55;
    for (int k = 0; k < 8; k++)
      chk_bit(b4[k], DIV, 0, $sformatf("t1_d%0d", k));
    chk_bit(1'b1, DIV - 1, 0, "t1_stop");
    chk("t1_busy_stop", busy, 1);
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_tx_end", tx, 1);
    chk("t1_rd_cnt", rd_cnt, 1);

    // three back-to-back frames, 2-cycle gaps
    rd0 = rd_cnt;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'hA5);
    wait_start(20, 0, "t2_wait");
    chk_frame(8'h00, DIV, 0, "t2_f0");
    chk_bit(1'b1, 2, 0, "t2_gap0");
    chk_frame(8'hFF, DIV, 0, "t2_f1");
    chk_bit(1'b1, 2, 0, "t2_gap1");
    chk_frame(8'hA5, DIV, 0, "t2_f2");
    chk("t2_rd_cnt", rd_cnt - rd0, 3);
    chk("t2_busy_end", busy, 0);

`ifdef RS232_SER_CTS_EN
    // CTS dropped mid-frame: frame completes, next held
    rd0 = rd_cnt;
    q.push_back(8'h12);
    q.push_back(8'h34);
    wait_start(20, 0, "t3_wait");
    b4 = 8'h12;
    chk_bit(1'b0, DIV, 0, "t3_start");
    for (int k = 0; k < 4; k++)
      chk_bit(b4[k], DIV, 0, $sformatf("t3_d%0d", k));
    cts_n = 1'b1;
    for (int k = 4; k < 8; k++)
      chk_bit(b4[k], DIV, 0, $sformatf("t3_d%0d", k));
    chk_bit(1'b1, DIV, 0, "t3_stop");
    chk_bit(1'b1, 3000, 0, "t3_hold");
    chk("t3_rd_held", rd_cnt - rd0, 1);
    chk("t3_busy_held", busy, 0);
    cts_n = 1'b0;
    chk_bit(1'b1, 5, 0, "t3_resume");
    chk_frame(8'h34, DIV, 0, "t3_f1");
    chk("t3_rd_cnt", rd_cnt - rd0, 2);
`endif

    // reset during data bit 4
    rd0 = rd_cnt;
    q.push_back(8'hE3);
    wait_start(20, 0, "t4_wait");
    b4 = 8'hE3;
    chk_bit(1'b0, DIV, 0, "t4_start");
    for (int k = 0; k < 4; k++)
      chk_bit(b4[k], DIV, 0, $sformatf("t4_d%0d", k));
    repeat (2) @(negedge clk);
    chk("t4_bit4_low", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_tx", tx, 1);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_rd", ff.rd_en, 0);
    chk("t4_rd_lost", rd_cnt - rd0, 1);
    @(negedge clk);
    q.push_back(8'h69);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("t4_rd_hold", ff.rd_en, 0);
    repeat (LAT) @(negedge clk);
    chk("t4_rd_fresh", ff.rd_en, 1);
    chk_bit(1'b1, 2, 0, "t4_pre");
    chk_frame(8'h69, DIV, 0, "t4_f");
    chk("t4_rd_cnt", rd_cnt - rd0, 2);

    // DIV=3 instance
    empty3 = 1'b0;
    n = 0;
    while (rd3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rd", rd3, 1);
    @(negedge clk);
    empty3 = 1'b1;
    chk_bit(1'b1, 1, 1, "t5_pre");
    chk_frame(8'hC3, DIV3, 1, "t5_f");
    chk("t5_busy_end", busy3, 0);
    chk("t5_rd_cnt", rd3_cnt, 1);

    chk("rd_while_empty", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
